// File: rtl/vec_exec_unit.sv
// Packed-SIMD execute stage: lane-wise saturating add/sub, Qm.n multiply,
// signed compare and arithmetic shift behind a busy/valid handshake.
module vec_exec_unit #(
  parameter int LANES = 4,
  parameter int LW    = 16,
  parameter int FRAC  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  add,
  input  logic                  sub,
  input  logic                  mul,
  input  logic                  compare,
  input  logic                  shift,
  input  logic                  sfmx,
  input  logic                  root,
  input  logic                  exp,
  input  logic [LANES*LW-1:0]   data_out1,
  input  logic [LANES*LW-1:0]   data_out2,
  output logic                  busy,
  output logic                  res_valid,
  output logic [LANES*LW-1:0]   data_in_comp,
  output logic                  op_err
);

  localparam int W  = LANES * LW;
  localparam int SW = $clog2(LW);
  localparam logic signed [2*LW:0] LMAX = {{(LW+2){1'b0}}, {(LW-1){1'b1}}};
  localparam logic signed [2*LW:0] LMIN = {{(LW+2){1'b1}}, {(LW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, EXEC, MUL2, DONE} state_t;
  typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_MUL, OP_CMP, OP_SHR} op_t;

  function automatic logic [LW-1:0] sat_sum(input logic signed [LW:0] v);
    logic [LW-1:0] r;
    if (v[LW] != v[LW-1]) begin
      r = v[LW] ? {1'b1, {(LW-1){1'b0}}} : {1'b0, {(LW-1){1'b1}}};
    end else begin
      r = v[LW-1:0];
    end
    return r;
  endfunction

  function automatic logic [LW-1:0] lane_exec(input op_t op, input logic [LW-1:0] a,
                                              input logic [LW-1:0] b);
    logic signed [LW:0] ax, bx;
    logic [LW-1:0] r;
    ax = {a[LW-1], a};
    bx = {b[LW-1], b};
    case (op)
      OP_ADD:  r = sat_sum(ax + bx);
      OP_SUB:  r = sat_sum(ax - bx);
      OP_CMP:  r = ($signed(a) > $signed(b)) ? {{(LW-1){1'b0}}, 1'b1} : {LW{1'b0}};
      OP_SHR:  r = $unsigned($signed(a) >>> b[SW-1:0]);
      default: r = {LW{1'b0}};
    endcase
    return r;
  endfunction

  function automatic logic [2*LW-1:0] lane_mul(input logic [LW-1:0] a, input logic [LW-1:0] b);
    logic signed [2*LW-1:0] p;
    p = $signed(a) * $signed(b);
    return p;
  endfunction

  // Round half-up at bit FRAC, drop the fraction, clamp to the lane range.
  function automatic logic [LW-1:0] lane_round(input logic [2*LW-1:0] p);
    logic signed [2*LW:0] r;
    logic [LW-1:0] q;
    r = $signed({p[2*LW-1], p}) + $signed({{(2*LW-FRAC+1){1'b0}}, 1'b1, {(FRAC-1){1'b0}}});
    r = r >>> FRAC;
    if (r > LMAX) begin
      q = {1'b0, {(LW-1){1'b1}}};
    end else if (r < LMIN) begin
      q = {1'b1, {(LW-1){1'b0}}};
    end else begin
      q = r[LW-1:0];
    end
    return q;
  endfunction

  state_t                     state_q, state_d;
  op_t                        op_q, op_d;
  logic [W-1:0]               a_q, a_d, b_q, b_d, res_q, res_d, data_q, data_d;
  logic [LANES-1:0][2*LW-1:0] prod_q, prod_d;
  logic                       busy_q, busy_d, valid_q, valid_d, err_q, err_d;
  logic [7:0]                 strobes;
  logic                       any_strobe, one_hot, supported;

  assign strobes    = {add, sub, mul, compare, shift, sfmx, root, exp};
  assign any_strobe = (strobes != 8'h00);
  assign one_hot    = any_strobe && ((strobes & (strobes - 8'd1)) == 8'h00);
  assign supported  = add | sub | mul | compare | shift;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    prod_d  = prod_q;
    data_d  = data_q;
    busy_d  = busy_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (one_hot && supported) begin
          a_d     = data_out1;
          b_d     = data_out2;
          busy_d  = 1'b1;
          state_d = EXEC;
          if (add) begin
            op_d = OP_ADD;
          end else if (sub) begin
            op_d = OP_SUB;
          end else if (mul) begin
            op_d = OP_MUL;
          end else if (compare) begin
            op_d = OP_CMP;
          end else begin
            op_d = OP_SHR;
          end
        end else begin
          err_d = any_strobe;
        end
      end
      EXEC: begin
        err_d = any_strobe;
        if (op_q == OP_MUL) begin
          for (int i = 0; i < LANES; i++) begin
            prod_d[i] = lane_mul(a_q[i*LW +: LW], b_q[i*LW +: LW]);
          end
          state_d = MUL2;
        end else begin
          for (int i = 0; i < LANES; i++) begin
            res_d[i*LW +: LW] = lane_exec(op_q, a_q[i*LW +: LW], b_q[i*LW +: LW]);
          end
          state_d = DONE;
        end
      end
      MUL2: begin
        err_d = any_strobe;
        for (int i = 0; i < LANES; i++) begin
          res_d[i*LW +: LW] = lane_round(prod_q[i]);
        end
        state_d = DONE;
      end
      DONE: begin
        err_d   = any_strobe;
        data_d  = res_q;
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_ADD;
      a_q     <= {W{1'b0}};
      b_q     <= {W{1'b0}};
      res_q   <= {W{1'b0}};
      prod_q  <= {(LANES*2*LW){1'b0}};
      data_q  <= {W{1'b0}};
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      prod_q  <= prod_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign busy         = busy_q;
  assign res_valid    = valid_q;
  assign data_in_comp = data_q;
  assign op_err       = err_q;

endmodule

// File: tb/tb_vec_exec_unit.sv
// Scoreboard bench for vec_exec_unit: directed vectors push expected results
// and op_err cycles; a negedge monitor pops and compares on each pulse.
module tb_vec_exec_unit;

  localparam logic [7:0] S_ADD = 8'h80, S_SUB = 8'h40, S_MUL = 8'h20, S_CMP = 8'h10,
                         S_SHR = 8'h08, S_EXP = 8'h01;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        add = 1'b0, sub = 1'b0, mul = 1'b0, compare = 1'b0, shift = 1'b0;
  logic        sfmx = 1'b0, root = 1'b0, exp = 1'b0;
  logic [63:0] data_out1 = 64'h0, data_out2 = 64'h0;
  logic        busy, res_valid, op_err;
  logic [63:0] data_in_comp;

  typedef struct {
    logic [63:0] d;
    int          c;
  } exp_t;

  exp_t        rq[$];
  int          eq[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [63:0] last_data = 64'h0;

  vec_exec_unit dut (
    .clk(clk), .rst(rst), .add(add), .sub(sub), .mul(mul), .compare(compare),
    .shift(shift), .sfmx(sfmx), .root(root), .exp(exp),
    .data_out1(data_out1), .data_out2(data_out2),
    .busy(busy), .res_valid(res_valid), .data_in_comp(data_in_comp), .op_err(op_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Monitor: every result or error pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (res_valid) begin
      checks++;
      if (rq.size() == 0) begin
        errors++;
        $display("FAIL result: unexpected res_valid data %h at cycle %0d", data_in_comp, cyc);
      end else begin
        exp_t e;
        e = rq.pop_front();
        if (data_in_comp !== e.d || cyc != e.c) begin
          errors++;
          $display("FAIL result: got %h at cycle %0d expected %h at cycle %0d",
                   data_in_comp, cyc, e.d, e.c);
        end
      end
    end
    if (op_err) begin
      checks++;
      if (eq.size() == 0) begin
        errors++;
        $display("FAIL op_err: unexpected pulse at cycle %0d", cyc);
      end else begin
        int c;
        c = eq.pop_front();
        if (cyc != c) begin
          errors++;
          $display("FAIL op_err: pulse at cycle %0d expected cycle %0d", cyc, c);
        end
      end
    end
  end

  // lat == 0 means no result is expected from this strobe.
  task automatic issue(input logic [7:0] s, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] ed, input int lat, input bit eerr, input bit ebusy);
    @(posedge clk);
    #1;
    {add, sub, mul, compare, shift, sfmx, root, exp} = s;
    data_out1 = a;
    data_out2 = b;
    if (lat != 0) begin
      rq.push_back('{d: ed, c: cyc + lat});
      last_data = ed;
    end
    if (eerr) eq.push_back(cyc + 1);
    @(posedge clk);
    @(negedge clk);
    check("busy_after_strobe", {63'h0, busy}, {63'h0, ebusy});
    {add, sub, mul, compare, shift, sfmx, root, exp} = 8'h00;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40; i++) begin
      if (rq.size() == 0 && eq.size() == 0) break;
      @(posedge clk);
    end
    @(negedge clk);
    if (rq.size() != 0 || eq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: %0d results and %0d op_err pulses outstanding", rq.size(), eq.size());
      rq.delete();
      eq.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_busy", {63'h0, busy}, 64'h0);
    check("reset_valid", {63'h0, res_valid}, 64'h0);
    check("reset_err", {63'h0, op_err}, 64'h0);
    check("reset_data", data_in_comp, 64'h0);

    issue(S_ADD, 64'h7000_0001_8000_0005, 64'h2000_0002_FFFF_0003,
          64'h7FFF_0003_8000_0008, 3, 1'b0, 1'b1);
    wait_done();
    check("add_data_held", data_in_comp, 64'h7FFF_0003_8000_0008);

    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("idle_rst_busy", {63'h0, busy}, 64'h0);
    check("idle_rst_valid", {63'h0, res_valid}, 64'h0);
    check("idle_rst_err", {63'h0, op_err}, 64'h0);
    check("idle_rst_data", data_in_comp, 64'h0);

    issue(S_SUB, 64'h8000_7FFF_0010_0000, 64'h0001_FFFF_0020_8000,
          64'h8000_7FFF_FFF0_7FFF, 3, 1'b0, 1'b1);
    wait_done();
    issue(S_MUL, 64'h0180_FF00_7F00_0000, 64'h0200_0080_0400_1234,
          64'h0300_FF80_7FFF_0000, 4, 1'b0, 1'b1);
    wait_done();
    issue(S_MUL, 64'h0080_FF80_8000_8000, 64'h0001_0001_8000_7FFF,
          64'h0001_0000_7FFF_8000, 4, 1'b0, 1'b1);
    wait_done();
    issue(S_CMP, 64'h0005_FFFD_0000_0007, 64'h0004_0002_0000_FFFF,
          64'h0001_0000_0000_0001, 3, 1'b0, 1'b1);
    wait_done();
    issue(S_SHR, 64'h8000_7FFF_FFF0_0100, 64'h0004_0001_0002_0018,
          64'hF800_3FFF_FFFC_0001, 3, 1'b0, 1'b1);
    wait_done();

    issue(S_ADD | S_MUL, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
          64'h0, 0, 1'b1, 1'b0);
    wait_done();
    check("dual_strobe_data", data_in_comp, last_data);
    issue(S_EXP, 64'h1, 64'h2, 64'h0, 0, 1'b1, 1'b0);
    wait_done();
    check("exp_data_unchanged", data_in_comp, last_data);

    issue(S_MUL, 64'h0100_0100_FFFF_0003, 64'h0100_FF00_0001_0055,
          64'h0100_FF00_0000_0001, 4, 1'b0, 1'b1);
    issue(S_SUB, 64'h0001_0001_0001_0001, 64'h0001_0001_0001_0001,
          64'h0, 0, 1'b1, 1'b1);
    wait_done();

    // Second add strobed on the first cycle busy is low.
    issue(S_ADD, 64'h0001_0001_0001_0001, 64'h0001_0002_0003_0004,
          64'h0002_0003_0004_0005, 3, 1'b0, 1'b1);
    @(posedge clk);
    issue(S_SUB, 64'h0000_0000_0000_0000, 64'h0001_0002_0003_0004,
          64'hFFFF_FFFE_FFFD_FFFC, 3, 1'b0, 1'b1);
    wait_done();

    issue(S_MUL, 64'h0100_0200_0300_0400, 64'h0100_0100_0100_0100,
          64'h0, 0, 1'b0, 1'b1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midop_rst_busy", {63'h0, busy}, 64'h0);
    check("midop_rst_data", data_in_comp, 64'h0);
    repeat (4) @(negedge clk);
    check("midop_rst_no_result", data_in_comp, 64'h0);
    issue(S_ADD, 64'h0001_0002_0003_0004, 64'h0010_0020_0030_0040,
          64'h0011_0022_0033_0044, 3, 1'b0, 1'b1);
    wait_done();
    check("final_data", data_in_comp, 64'h0011_0022_0033_0044);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
